// File: rtl/jk_down_counter_if.sv
// Control/status bundle for jk_down_counter: load/din/en in, q/tc/busy/done out.
interface jk_down_counter_if #(
  parameter int WIDTH = 5
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             en;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (output load, din, en, input q, tc, busy, done);
  modport slave  (input load, din, en, output q, tc, busy, done);
endinterface

// File: rtl/jk_down_counter.sv
// Programmable down counter from toggle-mode JK bits with terminal-count pulse.
// Define JKDOWN_RELOAD_EN to auto-reload the last loaded value after each 1->0 step.
module jk_down_counter #(
  parameter int WIDTH = 5
) (
  input logic              clk,
  input logic              clear,
  jk_down_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] t;
  logic             dec;
  logic             q_one;
  logic             q_zero;

  // Load outranks counting, so a load on the final step suppresses tc.
  assign dec    = (state_q == RUN) && bus.en && !bus.load;
  assign q_one  = (q_q == WIDTH'(1));
  assign q_zero = (q_q == '0);

  // Borrow chain: bit i toggles when every lower bit is already 0.
  assign t[0] = dec;
  for (genvar i = 1; i < WIDTH; i++) begin : g_borrow
    assign t[i] = t[i-1] & ~q_q[i-1];
  end

`ifdef JKDOWN_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tc_d    = 1'b0;
`ifdef JKDOWN_RELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.load) begin
      q_d     = bus.din;
      state_d = (bus.din != '0) ? RUN : DONE;
`ifdef JKDOWN_RELOAD_EN
      reload_d = bus.din;
`endif
    end else if (dec) begin
`ifdef JKDOWN_RELOAD_EN
      // Zero is a visible count step here; the next enabled edge restarts.
      if (q_zero) q_d = reload_q;
      else        q_d = q_q ^ t;
      tc_d = q_one;
`else
      if (!q_zero) q_d = q_q ^ t;
      tc_d = q_one;
      if (q_one) state_d = DONE;
`endif
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      q_q     <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef JKDOWN_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef JKDOWN_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign bus.q    = q_q;
  assign bus.tc   = tc_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_jk_down_counter.sv
// Directed-vector bench for jk_down_counter (both build configurations).
module tb_jk_down_counter;
`ifdef JKDOWN_RELOAD_EN
  localparam bit RL = 1'b1;
`else
  localparam bit RL = 1'b0;
`endif

  logic clk = 1'b0;
  logic clear;
  int   checks = 0;
  int   errors = 0;

  jk_down_counter_if #(.WIDTH(5)) bus ();
  jk_down_counter #(.WIDTH(5)) dut (.clk(clk), .clear(clear), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [4:0] din;
    logic       en;
    logic [4:0] q;
    logic       tc;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic ld, logic [4:0] din, logic en,
                              logic [4:0] q, logic tc, logic busy, logic done);
    vec_t v;
    v.ld = ld; v.din = din; v.en = en;
    v.q = q; v.tc = tc; v.busy = busy; v.done = done;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic ld, input logic [4:0] d, input logic e);
    bus.load = ld; bus.din = d; bus.en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [4:0] eq, input logic etc,
                     input logic eb, input logic ed);
    checks++;
    if ({bus.q, bus.tc, bus.busy, bus.done} !== {eq, etc, eb, ed}) begin
      errors++;
      $display("FAIL %s: got q=%0d tc=%b busy=%b done=%b, want q=%0d tc=%b busy=%b done=%b",
               nm, bus.q, bus.tc, bus.busy, bus.done, eq, etc, eb, ed);
    end
  endtask

  initial begin
    // Basic count 5..0
    add(1, 5, 1, 5, 0, 1, 0);
    for (int k = 4; k >= 1; k--) add(0, 0, 1, 5'(k), 0, 1, 0);
    add(0, 0, 1, 0, 1, RL, !RL);
    if (RL) add(0, 0, 1, 5, 0, 1, 0);
    else    add(0, 0, 1, 0, 0, 0, 1);
    // Enable gaps: 3,2,2,1,1,0
    add(1, 3, 0, 3, 0, 1, 0);
    add(0, 0, 1, 2, 0, 1, 0);
    add(0, 0, 0, 2, 0, 1, 0);
    add(0, 0, 1, 1, 0, 1, 0);
    add(0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 0, 1, RL, !RL);
    add(0, 0, 0, 0, 0, RL, !RL);
    if (RL) add(0, 0, 1, 3, 0, 1, 0);
    // Reload mid-count, then load on the 1->0 step
    add(1, 20, 1, 20, 0, 1, 0);
    for (int k = 19; k >= 12; k--) add(0, 0, 1, 5'(k), 0, 1, 0);
    add(1, 7, 1, 7, 0, 1, 0);
    for (int k = 6; k >= 1; k--) add(0, 0, 1, 5'(k), 0, 1, 0);
    add(1, 9, 1, 9, 0, 1, 0);
    // din = 0 goes straight to DONE
    add(1, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1);
    // din = 1 edge case
    add(1, 1, 0, 1, 0, 1, 0);
    add(0, 0, 1, 0, 1, RL, !RL);
    if (RL) begin
      add(0, 0, 1, 1, 0, 1, 0);
      // Period din+1 with din=2: 2,1,0,2,1,0
      add(1, 2, 1, 2, 0, 1, 0);
      add(0, 0, 1, 1, 0, 1, 0);
      add(0, 0, 1, 0, 1, 1, 0);
      add(0, 0, 1, 2, 0, 1, 0);
      add(0, 0, 1, 1, 0, 1, 0);
      add(0, 0, 1, 0, 1, 1, 0);
      add(0, 0, 1, 2, 0, 1, 0);
    end

    bus.load = 1'b0; bus.din = '0; bus.en = 1'b0;
    clear = 1'b0;
    #2;
    chk("reset_state", 0, 0, 0, 0);
    clear = 1'b1;
    step(0, 0, 1);
    chk("idle_ignores_en", 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].ld, tbl[i].din, tbl[i].en);
      chk($sformatf("vec%0d", i), tbl[i].q, tbl[i].tc, tbl[i].busy, tbl[i].done);
    end

    // Full-range count from 31, no wrap
    step(1, 31, 1);
    chk("max_load", 31, 0, 1, 0);
    for (int k = 30; k >= 1; k--) begin
      step(0, 0, 1);
      chk($sformatf("max_cnt%0d", k), 5'(k), 0, 1, 0);
    end
    step(0, 0, 1);
    chk("max_tc", 0, 1, RL, !RL);
    if (RL) begin
      step(0, 0, 1);
      chk("max_reload", 31, 0, 1, 0);
    end else begin
      for (int k = 0; k < 10; k++) begin
        step(0, 0, 1);
        chk($sformatf("max_hold%0d", k), 0, 0, 0, 1);
      end
    end

    // Asynchronous clear mid-count with load and en high
    step(1, 5, 1);
    step(0, 0, 1);
    chk("pre_clear", 4, 0, 1, 0);
    #2;
    bus.load = 1'b1; bus.din = 5'd9; bus.en = 1'b1;
    clear = 1'b0;
    #1;
    chk("clear_async", 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      step(1, 9, 1);
      chk($sformatf("clear_hold%0d", k), 0, 0, 0, 0);
    end
    clear = 1'b1;
    step(0, 0, 1);
    chk("post_clear_idle", 0, 0, 0, 0);
    step(1, 3, 1);
    chk("post_clear_load", 3, 0, 1, 0);
    step(0, 0, 1);
    chk("post_clear_count", 2, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jk_down_counter.md
# jk_down_counter

Synchronous programmable down counter built from JK flip-flops in toggle mode. It is the counting-down counterpart of the team's 5-bit JK up counter. It loads a start value, decrements on each enabled clock edge, and flags terminal count. Other blocks use it as a countdown timer or event divider.

## Interface
- WIDTH, 5, counter width in bits (min 2).
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous, active-low reset.
- load  input  1  synchronous load strobe; captures din.
- din  input  WIDTH  start value for load.
- en  input  1  count enable; decrement while RUN.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, one cycle.
- busy  output  1  high while state is RUN.
- done  output  1  high while state is DONE.

## Operation
- Counter bits are JK flip-flops in toggle mode (J=K=t). Bit i toggles when en is active and bits 0..i-1 are all 0 (borrow chain). Bit 0 toggles on every enabled decrement.
- All flip-flops share clk; there is no ripple clocking. q, tc, busy and done are all registered.
- States:
  - IDLE: after reset; q=0; ignores en.
  - RUN: decrements while en=1.
  - DONE: count exhausted; q holds 0.
- Transitions:
  - Any state, load=1, din≠0 -> RUN, q=din.
  - Any state, load=1, din=0 -> DONE, q=0, tc stays 0.
  - RUN, en=1, q=1 -> q=0, tc=1 for the next cycle, then DONE (configuration below changes this).
  - RUN, en=1, q>1 -> q=q-1.
  - RUN, en=0 -> hold.
  - DONE -> holds until load.
- Priority: load over en; reset over everything.
- q never wraps from 0 to all-ones. Decrement is only applied when q≥1 in RUN.
- Reset values (clear=0): q=0, tc=0, busy=0, done=0, state IDLE, reload register 0.

## Timing
- Load latency: load sampled at edge N gives q=din and busy=1 after edge N.
- Counting: from load at edge N with en held high, q reaches 0 after edge N+din. tc is high exactly for the cycle after edge N+din.
- done rises together with tc (non-reload build).
- en low cycles stretch the count one-for-one; tc is never asserted on a cycle where en was low at the edge.
- load in the same cycle as the 1->0 step: the load wins and tc stays 0.
- clear asserted mid-count forces reset values immediately, without waiting for clk. Counting resumes only after clear is released and a new load occurs.

## Configuration
- JKDOWN_RELOAD_EN defined:
  - Each load also stores din in a reload register.
  - In RUN, on the 1->0 step, q=0 and tc=1, and the state stays RUN.
  - On the next enabled edge, q=reload value.
  - Period = din+1 enabled edges. done never asserts unless load with din=0.
- JKDOWN_RELOAD_EN undefined: no reload register; RUN -> DONE at 0 as described in Operation.

## Test plan
- Reset: clear=0 mid-simulation with load=1 and en=1 -> q=0, tc=0, busy=0, done=0 immediately and held.
- Basic count: load din=5, en=1 -> q steps 5,4,3,2,1,0 on consecutive edges; tc high one cycle with q=0; done=1; q stays 0 for 10 more cycles.
- Enable gaps: load din=3, en toggles 1,0,1,0,1 -> q goes 3,2,2,1,1,0; tc asserts only after the final enabled edge.
- Reload mid-count and load priority: load 20, count to 12, load 7 -> q=7 next edge. Load 9 on the same edge where q=1 and en=1 -> q=9, tc=0.
- Boundary values: load din=0 -> done=1, tc=0, busy=0. Load din=31 (WIDTH=5) -> 31 enabled edges to 0, no wrap to 31.
- JKDOWN_RELOAD_EN: load din=2, en=1 -> q sequence 2,1,0,2,1,0,... with tc every 3rd cycle; busy stays 1 and done stays 0.
